// File: rtl/load_use_interlock.sv
// load_use_interlock: load-use stall/bubble controller with a 2-slot in-flight load scoreboard
`ifndef HBIT_SRC_GP
`define HBIT_SRC_GP 3
`endif
`ifndef HBIT_TGT_GP
`define HBIT_TGT_GP 3
`endif
`ifndef HBIT_SRC_SR
`define HBIT_SRC_SR 2
`endif
`ifndef HBIT_TGT_SR
`define HBIT_TGT_SR 2
`endif
module load_use_interlock #(
  parameter int CNT_W = 16
) (
  input  logic                  iw_clk,
  input  logic                  iw_rst,
  input  logic                  iw_id_valid,
  input  logic [`HBIT_SRC_GP:0] iw_id_src_gp,
  input  logic                  iw_id_src_gp_re,
  input  logic [`HBIT_TGT_GP:0] iw_id_tgt_gp,
  input  logic                  iw_id_tgt_gp_re,
  input  logic                  iw_id_tgt_gp_we,
  input  logic [`HBIT_SRC_SR:0] iw_id_src_sr,
  input  logic                  iw_id_src_sr_re,
  input  logic [`HBIT_TGT_SR:0] iw_id_tgt_sr,
  input  logic                  iw_id_tgt_sr_re,
  input  logic                  iw_id_tgt_sr_we,
  input  logic                  iw_id_is_load,
  input  logic                  iw_flush,
  input  logic                  iw_mem_busy,
  input  logic                  iw_stall_cnt_clr,
  output logic                  or_stall,
  output logic                  or_bubble,
  output logic [1:0]            or_hazard_slot,
  output logic [CNT_W-1:0]      or_stall_count
);
  logic [1:0]            s_valid;
  logic [1:0]            s_gp_we;
  logic [1:0]            s_sr_we;
  logic [`HBIT_TGT_GP:0] s_gp_idx [2];
  logic [`HBIT_TGT_SR:0] s_sr_idx [2];
  logic                  live;
  logic                  hazard;
  logic                  load_in;
  assign live    = iw_id_valid & ~iw_flush & ~iw_rst;
  assign hazard  = |or_hazard_slot;
  assign load_in = iw_id_valid & ~iw_flush & ~hazard & iw_id_is_load & (iw_id_tgt_gp_we | iw_id_tgt_sr_we);
  assign or_stall  = hazard | iw_mem_busy;
  assign or_bubble = hazard & ~iw_mem_busy;
  // per-slot match of every enabled ID read port against the load it tracks; GP and SR never cross
  always_comb begin
    or_hazard_slot = '0;
    for (int k = 0; k < 2; k++)
      or_hazard_slot[k] = live & s_valid[k] & (
          (iw_id_src_gp_re & s_gp_we[k] & (s_gp_idx[k] == iw_id_src_gp))
        | (iw_id_tgt_gp_re & s_gp_we[k] & (s_gp_idx[k] == iw_id_tgt_gp))
        | (iw_id_src_sr_re & s_sr_we[k] & (s_sr_idx[k] == iw_id_src_sr))
        | (iw_id_tgt_sr_re & s_sr_we[k] & (s_sr_idx[k] == iw_id_tgt_sr)));
  end
  // shift the load scoreboard one stage per non-frozen cycle; only issuing loads occupy exma
  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      s_valid <= '0;
      s_gp_we <= '0;
      s_sr_we <= '0;
      for (int k = 0; k < 2; k++) begin
        s_gp_idx[k] <= '0;
        s_sr_idx[k] <= '0;
      end
    end else if (!iw_mem_busy) begin
      s_valid[1]  <= s_valid[0];
      s_gp_we[1]  <= s_gp_we[0];
      s_sr_we[1]  <= s_sr_we[0];
      s_gp_idx[1] <= s_gp_idx[0];
      s_sr_idx[1] <= s_sr_idx[0];
      s_valid[0]  <= load_in;
      s_gp_we[0]  <= load_in & iw_id_tgt_gp_we;
      s_sr_we[0]  <= load_in & iw_id_tgt_sr_we;
      s_gp_idx[0] <= load_in ? iw_id_tgt_gp : '0;
      s_sr_idx[0] <= load_in ? iw_id_tgt_sr : '0;
    end
  end
  // saturating count of bubble cycles; clear wins over increment
  always_ff @(posedge iw_clk) begin
    if (iw_rst || iw_stall_cnt_clr) or_stall_count <= '0;
    else if (or_bubble && !(&or_stall_count)) or_stall_count <= or_stall_count + CNT_W'(1);
  end
endmodule

// File: tb/tb_load_use_interlock.sv
// tb_load_use_interlock: directed plus random checks of load_use_interlock against an issue-history model
`ifndef HBIT_SRC_GP
`define HBIT_SRC_GP 3
`endif
`ifndef HBIT_TGT_GP
`define HBIT_TGT_GP 3
`endif
`ifndef HBIT_SRC_SR
`define HBIT_SRC_SR 2
`endif
`ifndef HBIT_TGT_SR
`define HBIT_TGT_SR 2
`endif
module tb_load_use_interlock;
  logic                  iw_clk = 0;
  logic                  iw_rst, iw_id_valid, iw_id_src_gp_re, iw_id_tgt_gp_re, iw_id_tgt_gp_we;
  logic [`HBIT_SRC_GP:0] iw_id_src_gp;
  logic [`HBIT_TGT_GP:0] iw_id_tgt_gp;
  logic [`HBIT_SRC_SR:0] iw_id_src_sr;
  logic [`HBIT_TGT_SR:0] iw_id_tgt_sr;
  logic                  iw_id_src_sr_re, iw_id_tgt_sr_re, iw_id_tgt_sr_we, iw_id_is_load;
  logic                  iw_flush, iw_mem_busy, iw_stall_cnt_clr;
  logic                  or_stall, or_bubble, stall3, bubble3;
  logic [1:0]            or_hazard_slot, slot3;
  logic [15:0]           or_stall_count;
  logic [2:0]            cnt3;
  int checks = 0, errors = 0;
  typedef struct {bit gw; int gi; bit sw; int si;} rec_t;
  rec_t hist[$];
  int exp_cnt16, exp_cnt3;
  bit cnt_ok;
  logic [1:0] obs_slot;
  logic obs_stall, obs_bubble;
  always #5 iw_clk = ~iw_clk;
  load_use_interlock dut (
    .iw_clk(iw_clk), .iw_rst(iw_rst), .iw_id_valid(iw_id_valid),
    .iw_id_src_gp(iw_id_src_gp), .iw_id_src_gp_re(iw_id_src_gp_re),
    .iw_id_tgt_gp(iw_id_tgt_gp), .iw_id_tgt_gp_re(iw_id_tgt_gp_re), .iw_id_tgt_gp_we(iw_id_tgt_gp_we),
    .iw_id_src_sr(iw_id_src_sr), .iw_id_src_sr_re(iw_id_src_sr_re),
    .iw_id_tgt_sr(iw_id_tgt_sr), .iw_id_tgt_sr_re(iw_id_tgt_sr_re), .iw_id_tgt_sr_we(iw_id_tgt_sr_we),
    .iw_id_is_load(iw_id_is_load), .iw_flush(iw_flush), .iw_mem_busy(iw_mem_busy),
    .iw_stall_cnt_clr(iw_stall_cnt_clr), .or_stall(or_stall), .or_bubble(or_bubble),
    .or_hazard_slot(or_hazard_slot), .or_stall_count(or_stall_count));
  load_use_interlock #(.CNT_W(3)) dut3 (
    .iw_clk(iw_clk), .iw_rst(iw_rst), .iw_id_valid(iw_id_valid),
    .iw_id_src_gp(iw_id_src_gp), .iw_id_src_gp_re(iw_id_src_gp_re),
    .iw_id_tgt_gp(iw_id_tgt_gp), .iw_id_tgt_gp_re(iw_id_tgt_gp_re), .iw_id_tgt_gp_we(iw_id_tgt_gp_we),
    .iw_id_src_sr(iw_id_src_sr), .iw_id_src_sr_re(iw_id_src_sr_re),
    .iw_id_tgt_sr(iw_id_tgt_sr), .iw_id_tgt_sr_re(iw_id_tgt_sr_re), .iw_id_tgt_sr_we(iw_id_tgt_sr_we),
    .iw_id_is_load(iw_id_is_load), .iw_flush(iw_flush), .iw_mem_busy(iw_mem_busy),
    .iw_stall_cnt_clr(iw_stall_cnt_clr), .or_stall(stall3), .or_bubble(bubble3),
    .or_hazard_slot(slot3), .or_stall_count(cnt3));
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  function automatic bit reads(rec_t r);
    return (iw_id_src_gp_re && r.gw && r.gi == int'(iw_id_src_gp))
        || (iw_id_tgt_gp_re && r.gw && r.gi == int'(iw_id_tgt_gp))
        || (iw_id_src_sr_re && r.sw && r.si == int'(iw_id_src_sr))
        || (iw_id_tgt_sr_re && r.sw && r.si == int'(iw_id_tgt_sr));
  endfunction
  // slot i is the instruction that advanced into EX i+1 non-frozen cycles ago
  function automatic logic [1:0] exp_slot();
    logic [1:0] e = '0;
    if (iw_rst || !iw_id_valid || iw_flush) return e;
    for (int i = 0; i < 2; i++)
      if (hist.size() > i) e[i] = reads(hist[hist.size()-1-i]);
    return e;
  endfunction
  task automatic clr_in();
    iw_id_valid = 0; iw_id_src_gp = 0; iw_id_src_gp_re = 0; iw_id_tgt_gp = 0; iw_id_tgt_gp_re = 0;
    iw_id_tgt_gp_we = 0; iw_id_src_sr = 0; iw_id_src_sr_re = 0; iw_id_tgt_sr = 0; iw_id_tgt_sr_re = 0;
    iw_id_tgt_sr_we = 0; iw_id_is_load = 0; iw_flush = 0; iw_mem_busy = 0; iw_stall_cnt_clr = 0; iw_rst = 0;
  endtask
  task automatic cyc();
    logic [1:0] es;
    logic eh, eb;
    rec_t r;
    #1;
    es = exp_slot();
    eh = |es;
    eb = eh & ~iw_mem_busy;
    chk("hazard_slot", {30'b0, or_hazard_slot}, {30'b0, es});
    chk("stall", {31'b0, or_stall}, {31'b0, eh | iw_mem_busy});
    chk("bubble", {31'b0, or_bubble}, {31'b0, eb});
    chk("hazard_slot_w3", {30'b0, slot3}, {30'b0, es});
    if (cnt_ok) begin
      chk("count", {16'b0, or_stall_count}, exp_cnt16);
      chk("count_w3", {29'b0, cnt3}, exp_cnt3);
    end
    obs_slot = or_hazard_slot; obs_stall = or_stall; obs_bubble = or_bubble;
    @(posedge iw_clk);
    if (iw_rst) begin
      hist.delete(); exp_cnt16 = 0; exp_cnt3 = 0;
    end else begin
      if (iw_stall_cnt_clr) begin exp_cnt16 = 0; exp_cnt3 = 0; end
      else if (eb) begin
        if (exp_cnt16 < 65535) exp_cnt16++;
        if (exp_cnt3 < 7) exp_cnt3++;
      end
      if (!iw_mem_busy) begin
        r = '{0, 0, 0, 0};
        if (iw_id_valid && !iw_flush && !eh && iw_id_is_load && (iw_id_tgt_gp_we || iw_id_tgt_sr_we))
          r = '{iw_id_tgt_gp_we, int'(iw_id_tgt_gp), iw_id_tgt_sr_we, int'(iw_id_tgt_sr)};
        hist.push_back(r);
        if (hist.size() > 2) void'(hist.pop_front());
      end
    end
    #1;
  endtask
  task automatic ld_gp(int idx);
    clr_in(); iw_id_valid = 1; iw_id_is_load = 1; iw_id_tgt_gp = idx[`HBIT_TGT_GP:0]; iw_id_tgt_gp_we = 1;
  endtask
  task automatic rd_gp(int idx);
    clr_in(); iw_id_valid = 1; iw_id_src_gp = idx[`HBIT_SRC_GP:0]; iw_id_src_gp_re = 1;
  endtask
  task automatic nop();
    clr_in(); iw_id_valid = 1;
  endtask
  initial begin
    clr_in(); iw_rst = 1; iw_mem_busy = 1; cnt_ok = 0;
    cyc();
    chk("reset_stall_eq_busy", {31'b0, obs_stall}, 32'd1);
    chk("reset_no_bubble", {31'b0, obs_bubble}, 32'd0);
    cnt_ok = 1;
    clr_in(); cyc();
    chk("reset_count", {16'b0, or_stall_count}, 32'd0);
    ld_gp(3); cyc();
    rd_gp(3); cyc(); chk("dep1_slot", {30'b0, obs_slot}, 32'b01);
    cyc(); chk("dep2_slot", {30'b0, obs_slot}, 32'b10);
    cyc(); chk("dep3_slot", {30'b0, obs_slot}, 32'b00);
    chk("dep_count", {16'b0, or_stall_count}, 32'd2);
    ld_gp(3); cyc(); nop(); cyc();
    rd_gp(3); cyc(); chk("gap1_slot", {30'b0, obs_slot}, 32'b10);
    cyc(); chk("gap1_done", {31'b0, obs_stall}, 32'd0);
    ld_gp(3); cyc(); nop(); cyc(); nop(); cyc();
    rd_gp(3); cyc(); chk("gap2_nostall", {31'b0, obs_stall}, 32'd0);
    clr_in(); iw_id_valid = 1; iw_id_is_load = 1; iw_id_tgt_sr = 2; iw_id_tgt_sr_we = 1; cyc();
    rd_gp(2); cyc(); chk("no_cross_file", {31'b0, obs_stall}, 32'd0);
    clr_in(); iw_id_valid = 1; iw_id_is_load = 1; iw_id_tgt_sr = 2; iw_id_tgt_sr_we = 1; cyc();
    clr_in(); iw_id_valid = 1; iw_id_src_sr = 2; iw_id_src_sr_re = 0; cyc();
    chk("sr_re_off", {31'b0, obs_stall}, 32'd0);
    clr_in(); iw_id_valid = 1; iw_id_is_load = 1; iw_id_tgt_sr = 2; iw_id_tgt_sr_we = 1; cyc();
    clr_in(); iw_id_valid = 1; iw_id_src_sr = 2; iw_id_src_sr_re = 1; cyc(); cyc();
    chk("sr_stall2", {30'b0, obs_slot}, 32'b10);
    clr_in(); iw_stall_cnt_clr = 1; cyc();
    ld_gp(5); cyc(); rd_gp(5); cyc();
    for (int i = 0; i < 3; i++) begin
      iw_mem_busy = 1; cyc();
      chk("busy_stall", {31'b0, obs_stall}, 32'd1);
      chk("busy_bubble", {31'b0, obs_bubble}, 32'd0);
      chk("busy_frozen_slot", {30'b0, obs_slot}, 32'b10);
    end
    iw_mem_busy = 0; cyc(); cyc();
    chk("busy_total", {16'b0, or_stall_count}, 32'd2);
    ld_gp(1); iw_id_src_gp = 1; iw_id_src_gp_re = 1; cyc();
    rd_gp(1); iw_flush = 1; cyc();
    chk("flush_no_stall", {31'b0, obs_stall}, 32'd0);
    rd_gp(1); cyc(); chk("flush_after", {30'b0, obs_slot}, 32'b10);
    ld_gp(4); cyc(); rd_gp(4); cyc(); iw_rst = 1; cyc();
    iw_rst = 0; cyc(); chk("post_reset_nostall", {31'b0, obs_stall}, 32'd0);
    chk("post_reset_count", {16'b0, or_stall_count}, 32'd0);
    for (int i = 0; i < 5; i++) begin ld_gp(6); cyc(); rd_gp(6); cyc(); cyc(); end
    clr_in(); cyc();
    chk("sat_w3", {29'b0, cnt3}, 32'd7);
    ld_gp(6); cyc(); rd_gp(6); iw_stall_cnt_clr = 1; cyc(); iw_stall_cnt_clr = 0; cyc();
    chk("clr_w_bubble_w3", {29'b0, cnt3}, 32'd1);
    for (int n = 0; n < 3000; n++) begin
      iw_rst = ($urandom_range(99) < 2);
      iw_id_valid = ($urandom_range(9) < 8);
      iw_id_src_gp = 4'($urandom_range(3)); iw_id_src_gp_re = 1'($urandom);
      iw_id_tgt_gp = 4'($urandom_range(3)); iw_id_tgt_gp_re = 1'($urandom); iw_id_tgt_gp_we = 1'($urandom);
      iw_id_src_sr = 3'($urandom_range(3)); iw_id_src_sr_re = 1'($urandom);
      iw_id_tgt_sr = 3'($urandom_range(3)); iw_id_tgt_sr_re = 1'($urandom); iw_id_tgt_sr_we = 1'($urandom);
      iw_id_is_load = ($urandom_range(9) < 5);
      iw_flush = ($urandom_range(9) == 0);
      iw_mem_busy = ($urandom_range(99) < 15);
      iw_stall_cnt_clr = ($urandom_range(99) < 3);
      cyc();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
